// File: rtl/cdb_pkg.sv
// Shared defaults, requester indices and output-state encoding for the CDB arbiter.
package cdb_pkg;

    localparam int CDB_NREQ_DEF   = 4;
    localparam int CDB_TAG_W_DEF  = 5;
    localparam int CDB_DATA_W_DEF = 32;

    localparam int CDB_ALU = 0;
    localparam int CDB_MUL = 1;
    localparam int CDB_LSU = 2;
    localparam int CDB_BR  = 3;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BCAST = 2'd1,
        HOLD  = 2'd2
    } cdb_state_e;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational NREQ-way pick: first valid request found searching upward from ptr, wrapping.
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int SRC_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [SRC_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [SRC_W-1:0] idx,
    output logic             any_valid
);

    int               k;
    logic [SRC_W-1:0] kk;
    logic             found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        kk    = '0;
        for (int i = 0; i < NREQ; i++) begin
            k = int'(ptr) + i;
            if (k >= NREQ) k = k - NREQ;
            kk = SRC_W'(k);
            if (!found && req[kk]) begin
                found   = 1'b1;
                gnt[kk] = 1'b1;
                idx     = kk;
            end
        end
    end

    assign any_valid = |req;

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: grants one completion token per cycle and broadcasts it registered.
// Build option: define CDB_RR_EN for round-robin; otherwise fixed priority, lowest index wins.
//
// state | meaning
// EMPTY | no broadcast, RB_valid_cdb=0, tag/data/src cleared
// BCAST | token broadcast this cycle, RB_valid_cdb=1
// HOLD  | consumer stalled, broadcast frozen with RB_valid_cdb=1
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NREQ   = CDB_NREQ_DEF,
    parameter int TAG_W  = CDB_TAG_W_DEF,
    parameter int DATA_W = CDB_DATA_W_DEF,
    localparam int SRC_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NREQ-1:0]        Req_valid_cdb,
    input  logic [NREQ*TAG_W-1:0]  Req_tag_cdb,
    input  logic [NREQ*DATA_W-1:0] Req_data_cdb,
    output logic [NREQ-1:0]        Req_gnt_cdb,
    input  logic                   Stall_cdb,
    input  logic                   Flush_cdb,
    output logic                   RB_valid_cdb,
    output logic [TAG_W-1:0]       RB_tag_cdb,
    output logic [DATA_W-1:0]      RB_data_cdb,
    output logic [SRC_W-1:0]       RB_src_cdb
);

    cdb_state_e       state_q, state_d;
    logic [SRC_W-1:0] ptr;
    logic [NREQ-1:0]  pick_gnt;
    logic [SRC_W-1:0] pick_idx;
    logic             pick_any;
    logic             gnt_en;
    logic             gnt_any;

    rr_pick #(
        .NREQ  (NREQ),
        .SRC_W (SRC_W)
    ) u_pick (
        .req       (Req_valid_cdb),
        .ptr       (ptr),
        .gnt       (pick_gnt),
        .idx       (pick_idx),
        .any_valid (pick_any)
    );

    // reset is folded in so no requester sees a grant while the block is held in reset
    assign gnt_en      = reset & ~Stall_cdb & ~Flush_cdb;
    assign gnt_any     = gnt_en & pick_any;
    assign Req_gnt_cdb = gnt_en ? pick_gnt : '0;

`ifdef CDB_RR_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (pick_idx == SRC_W'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
        end
    end
`else
    assign ptr = '0;
`endif

    always_comb begin
        state_d = state_q;
        if (Flush_cdb) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (gnt_any) state_d = BCAST;
                end
                BCAST, HOLD: begin
                    if (Stall_cdb)     state_d = HOLD;
                    else if (gnt_any)  state_d = BCAST;
                    else               state_d = EMPTY;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // payload only loads on a grant; in HOLD no grant is possible so it stays frozen
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            RB_tag_cdb  <= '0;
            RB_data_cdb <= '0;
            RB_src_cdb  <= '0;
        end else if (state_d == EMPTY) begin
            RB_tag_cdb  <= '0;
            RB_data_cdb <= '0;
            RB_src_cdb  <= '0;
        end else if (gnt_any) begin
            RB_tag_cdb  <= Req_tag_cdb[pick_idx*TAG_W +: TAG_W];
            RB_data_cdb <= Req_data_cdb[pick_idx*DATA_W +: DATA_W];
            RB_src_cdb  <= pick_idx;
        end
    end

    assign RB_valid_cdb = (state_q != EMPTY);

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common Data Bus arbiter for the Tomasulo/ROB datapath. It collects completion tokens (ROB tag plus result) from the functional units and grants one per cycle. It drives a registered CDB broadcast `{RB_valid, RB_tag}` into the register status table, and the matching result data into the ROB. It also supplies backpressure and flush handling, so that the status table and ROB never see two completions in one cycle or a stale token after a mispredict.

## Interface
Parameters:
- NREQ, 4, number of requesting functional units (0=ALU, 1=MUL, 2=LSU, 3=BR)
- TAG_W, 5, ROB tag width
- DATA_W, 32, result data width

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- Req_valid_cdb  in  NREQ  requester i holds a completed result
- Req_tag_cdb  in  NREQ*TAG_W  ROB tag of requester i, slice [i*TAG_W +: TAG_W]
- Req_data_cdb  in  NREQ*DATA_W  result of requester i, slice [i*DATA_W +: DATA_W]
- Req_gnt_cdb  out  NREQ  one-hot combinational grant; requester i drops or advances its token on the edge where the grant is high
- Stall_cdb  in  1  ROB write port busy; freeze the bus
- Flush_cdb  in  1  mispredict recovery; discard in-flight broadcast
- RB_valid_cdb  out  1  broadcast valid (to the status table RB_valid)
- RB_tag_cdb  out  TAG_W  broadcast tag (to the status table RB_tag)
- RB_data_cdb  out  DATA_W  broadcast result
- RB_src_cdb  out  log2(NREQ)  index of the granted requester

## Operation
- Grant is the arbiter pick over Req_valid_cdb.
  - It is qualified: no grant while Stall_cdb=1 or Flush_cdb=1.
  - At most one Req_gnt_cdb bit is high; it is all-zero when no request is present.
- The output register has three states:
  - EMPTY: RB_valid_cdb=0. A grant moves it to BCAST, loading the tag, data and source.
  - BCAST: RB_valid_cdb=1 for one cycle. Next state:
    - another grant → BCAST with the new token;
    - no grant, no stall → EMPTY;
    - Stall_cdb=1 → HOLD.
  - HOLD: outputs frozen with valid held at 1; the consumer must not double-commit. When Stall_cdb drops, the state follows BCAST rules on that cycle's grant.
- Stall_cdb in EMPTY keeps the register EMPTY and issues no grants.
- Flush_cdb has priority over everything. On the next edge the state is EMPTY and RB_valid_cdb=0, and no grant is issued in the flush cycle. The arbitration pointer is not reset.
- Simultaneous Flush_cdb and Stall_cdb: flush wins.
- Requesters not granted must hold valid, tag and data stable; the arbiter stores no pending requests.
- RB_tag_cdb and RB_data_cdb are zero whenever state is EMPTY.

## Timing
- Reset values: RB_valid_cdb=0, RB_tag_cdb=0, RB_data_cdb=0, RB_src_cdb=0, state EMPTY, round-robin pointer=0.
- Req_gnt_cdb is 0 during reset.
- Latency: a request granted in cycle N is broadcast in cycle N+1. With no stall, throughput is 1 token/cycle.
- The round-robin pointer updates on the edge of a grant to (granted index + 1) mod NREQ.
- Pointer wrap: after a grant to index NREQ-1, the pointer returns to 0.
- Reset asserted mid-broadcast forces EMPTY immediately (asynchronous); tokens are lost and requesters re-present them after reset.

## Configuration
- CDB_RR_EN defined: round-robin arbitration; search starts at the pointer and wraps modulo NREQ.
- CDB_RR_EN undefined: fixed priority, lowest index wins (ALU > MUL > LSU > BR). The pointer register is not built.
- Reset, stall and flush behaviour are identical in both builds.

## Structure
- Package `cdb_pkg` holds:
  - NREQ, TAG_W, DATA_W defaults;
  - requester index constants (CDB_ALU, CDB_MUL, CDB_LSU, CDB_BR);
  - the output-state enum (EMPTY, BCAST, HOLD).
- Sub-module `rr_pick`: combinational NREQ-way pick.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, encoded index, any-valid.
  - Under CDB_RR_EN undefined it receives pointer=0.
- The top level holds the state register, output registers, pointer and qualifiers.

## Test plan
- Reset then release, no requests: all outputs 0 across 10 cycles; Req_gnt_cdb=0.
- Single request, requester 2, tag 5'h0A, data 32'hDEADBEEF, at cycle N:
  - cycle N: Req_gnt_cdb=4'b0100;
  - cycle N+1: RB_valid_cdb=1, RB_tag_cdb=5'h0A, RB_src_cdb=2;
  - cycle N+2: valid returns to 0.
- All four requesters held valid for 8 cycles:
  - with CDB_RR_EN, grant order is 0,1,2,3,0,1,2,3;
  - without CDB_RR_EN, requester 0 is granted 8 times.
- Stall_cdb high for 3 cycles while tag 5'h03 is in BCAST:
  - RB_valid_cdb=1, tag 5'h03 held for 4 cycles total;
  - no grants during the stall;
  - after release, the next requester is broadcast one cycle later.
- Flush_cdb pulsed with Stall_cdb also high, while tag 5'h07 is in HOLD:
  - next cycle RB_valid_cdb=0;
  - no grant in the flush cycle.
- Reset asserted mid-BCAST with tag 5'h1F: RB_valid_cdb falls to 0 without waiting for a clock edge.
